// File: rtl/wb_streamer_pkg.sv
// Shared constants for the Wishbone result streamer: register byte
// offsets, STATUS/CTRL bit positions and the stream engine states.
package wb_streamer_pkg;

   localparam int unsigned REG_DATA   = 32'h0;
   localparam int unsigned REG_STATUS = 32'h4;
   localparam int unsigned REG_CTRL   = 32'h8;
   localparam int unsigned REG_TXCNT  = 32'hC;

   localparam int ST_CNT_LSB = 0;
   localparam int ST_EMPTY   = 8;
   localparam int ST_FULL    = 9;
   localparam int ST_OVF     = 10;

   localparam int CT_EN      = 0;
   localparam int CT_IRQ_EN  = 1;
   localparam int CT_GAP_LSB = 8;

   typedef enum logic {
      ST_IDLE,
      ST_EMIT
   } stream_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// Ports: clk, rst (sync, high), push/din, pop/dout, full, empty, count.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp_q, wp_d;
   logic [PW-1:0] rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      full    = (cnt_q == CW'(DEPTH));
      empty   = (cnt_q == '0);
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      wp_d    = wp_q + PW'(do_push);
      rp_d    = rp_q + PW'(do_pop);
      cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
      dout    = mem[rp_q];
      count   = cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wp_q] <= din;
   end

endmodule

// File: rtl/wb_result_streamer.sv
// Wishbone classic slave buffering CPU result words and replaying them
// as a paced valid-qualified stream (alu_result_out / alu_valid_out).
// Ports: clk, rst (sync, high), wb_* slave bus, alu_result_out,
// alu_valid_out, irq. Optional macro WB_STREAMER_IRQ_EN enables irq.
module wb_result_streamer
   import wb_streamer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [AW-1:0] wb_adr_i,
   input  logic [31:0]   wb_dat_i,
   output logic [31:0]   wb_dat_o,
   output logic          wb_ack_o,
   output logic [31:0]   alu_result_out,
   output logic          alu_valid_out,
   output logic          irq
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = AW - 2;

   localparam logic [IW-1:0] IDX_DATA   = IW'(REG_DATA >> 2);
   localparam logic [IW-1:0] IDX_STATUS = IW'(REG_STATUS >> 2);
   localparam logic [IW-1:0] IDX_CTRL   = IW'(REG_CTRL >> 2);
   localparam logic [IW-1:0] IDX_TXCNT  = IW'(REG_TXCNT >> 2);

   logic          ack_q, ack_d;
   logic [31:0]   dat_q, dat_d;
   logic          en_q, en_d;
   logic          irq_en_q, irq_en_d;
   logic [7:0]    gap_q, gap_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    gcnt_q, gcnt_d;
   logic [31:0]   tx_q, tx_d;
   logic [31:0]   res_q, res_d;
   logic          vld_q, vld_d;
   stream_state_e st_q, st_d;

   logic          req, wr, rd;
   logic [IW-1:0] idx;
   logic          hit_data, hit_status, hit_ctrl, hit_tx;
   logic [31:0]   status_w, ctrl_w;

   logic          f_push, f_pop, f_full, f_empty;
   logic [CW-1:0] f_cnt;
   logic [31:0]   f_head;

   logic          unused_adr;
   assign unused_adr = ^wb_adr_i[1:0];

   sync_fifo #(
      .DEPTH (DEPTH),
      .W     (32)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (f_push),
      .din   (wb_dat_i),
      .pop   (f_pop),
      .dout  (f_head),
      .full  (f_full),
      .empty (f_empty),
      .count (f_cnt)
   );

   always_comb begin
      req        = wb_cyc_i & wb_stb_i & ~ack_q;
      wr         = req & wb_we_i;
      rd         = req & ~wb_we_i;
      idx        = wb_adr_i[AW-1:2];
      hit_data   = (idx == IDX_DATA);
      hit_status = (idx == IDX_STATUS);
      hit_ctrl   = (idx == IDX_CTRL);
      hit_tx     = (idx == IDX_TXCNT);

      status_w                    = '0;
      status_w[ST_CNT_LSB +: 8]   = 8'(f_cnt);
      status_w[ST_EMPTY]          = f_empty;
      status_w[ST_FULL]           = f_full;
      status_w[ST_OVF]            = ovf_q;

      ctrl_w                      = '0;
      ctrl_w[CT_EN]               = en_q;
      ctrl_w[CT_IRQ_EN]           = irq_en_q;
      ctrl_w[CT_GAP_LSB +: 8]     = gap_q;

      ack_d    = req;
      dat_d    = '0;
      en_d     = en_q;
      irq_en_d = irq_en_q;
      gap_d    = gap_q;
      ovf_d    = ovf_q;
      gcnt_d   = gcnt_q;
      tx_d     = tx_q;
      res_d    = res_q;
      vld_d    = 1'b0;
      st_d     = st_q;
      f_pop    = 1'b0;

      // Full is judged on the pre-edge count, even if a pop is due now.
      f_push = wr & hit_data & ~f_full;

      if (rd) begin
         unique case (1'b1)
            hit_status: dat_d = status_w;
            hit_ctrl:   dat_d = ctrl_w;
            hit_tx:     dat_d = tx_q;
            default:    dat_d = '0;
         endcase
      end

      if (wr & hit_data & f_full)
         ovf_d = 1'b1;
      if (wr & hit_status & wb_dat_i[ST_OVF])
         ovf_d = 1'b0;
      if (wr & hit_ctrl) begin
         en_d     = wb_dat_i[CT_EN];
         irq_en_d = wb_dat_i[CT_IRQ_EN];
         gap_d    = wb_dat_i[CT_GAP_LSB +: 8];
      end

      unique case (st_q)
         ST_IDLE: begin
            if (gcnt_q != '0)
               gcnt_d = gcnt_q - 8'd1;
            if (en_q & ~f_empty & (gcnt_q == '0))
               st_d = ST_EMIT;
         end
         ST_EMIT: begin
            // Completes even if enable dropped meanwhile.
            f_pop  = 1'b1;
            vld_d  = 1'b1;
            res_d  = f_head;
            tx_d   = tx_q + 32'd1;
            gcnt_d = gap_q;
            st_d   = ST_IDLE;
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         en_q     <= 1'b0;
         irq_en_q <= 1'b0;
         gap_q    <= '0;
         ovf_q    <= 1'b0;
         gcnt_q   <= '0;
         tx_q     <= '0;
         res_q    <= '0;
         vld_q    <= 1'b0;
         st_q     <= ST_IDLE;
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         en_q     <= en_d;
         irq_en_q <= irq_en_d;
         gap_q    <= gap_d;
         ovf_q    <= ovf_d;
         gcnt_q   <= gcnt_d;
         tx_q     <= tx_d;
         res_q    <= res_d;
         vld_q    <= vld_d;
         st_q     <= st_d;
      end
   end

   assign wb_ack_o       = ack_q;
   assign wb_dat_o       = dat_q;
   assign alu_result_out = res_q;
   assign alu_valid_out  = vld_q;

`ifdef WB_STREAMER_IRQ_EN
   logic irq_q, irq_d;

   always_comb begin
      irq_d = ovf_q | (irq_en_q & f_empty & (tx_q != '0));
   end

   always_ff @(posedge clk) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= irq_d;
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_wb_result_streamer.sv
// Self-checking bench for wb_result_streamer: queue-based model of the
// buffered words plus directed timing and register expectations.
module tb_wb_result_streamer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  adr = '0;
   logic [31:0] dat_i = '0;
   logic [31:0] dat_o;
   logic        ack;
   logic [31:0] res;
   logic        vld;
   logic        irq;

   wb_result_streamer #(.DEPTH(DEPTH), .AW(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .wb_cyc_i       (cyc),
      .wb_stb_i       (stb),
      .wb_we_i        (we),
      .wb_adr_i       (adr),
      .wb_dat_i       (dat_i),
      .wb_dat_o       (dat_o),
      .wb_ack_o       (ack),
      .alu_result_out (res),
      .alu_valid_out  (vld),
      .irq            (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Model state
   logic [31:0] mq[$];
   bit          m_ovf = 0;
   int          m_tx = 0;
   int          pulse_cnt = 0;
   int          pcyc[$];
   logic [31:0] last_res = '0;
   int          last_pc = -1;
   int          last_gap = 0;
   int          cur_gap = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h",
                  name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s = '0;
      s[7:0] = 8'(mq.size());
      s[8]   = (mq.size() == 0);
      s[9]   = (mq.size() == DEPTH);
      s[10]  = m_ovf;
      return s;
   endfunction

   // Per-cycle monitor of the stream outputs.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            last_res = '0;
            last_pc  = -1;
         end else if (vld) begin
            if (mq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse actual=0x%08h required=none",
                        res);
            end else begin
               chk("pulse_data", res, mq.pop_front());
            end
            if (last_pc >= 0) begin
               checks++;
               if (cyc_n - last_pc < 2 + last_gap) begin
                  failures++;
                  $display("FAIL pulse_spacing actual=%0d required>=%0d",
                           cyc_n - last_pc, 2 + last_gap);
               end
            end
            last_pc  = cyc_n;
            last_gap = cur_gap;
            pcyc.push_back(cyc_n);
            pulse_cnt++;
            m_tx++;
            last_res = res;
         end else begin
            chk("result_hold", res, last_res);
         end
`ifndef WB_STREAMER_IRQ_EN
         chk("irq_off", {31'b0, irq}, 32'h0);
`endif
      end
   end

   task automatic xfer(input bit w, input logic [3:0] a,
                       input logic [31:0] d, output logic [31:0] rdat,
                       output int acyc);
      bit got;
      got  = 0;
      rdat = '0;
      acyc = -1;
      cyc = 1; stb = 1; we = w; adr = a; dat_i = d;
      for (int i = 0; i < 6 && !got; i++) begin
         @(posedge clk);
         #1;
         if (ack) begin
            got  = 1;
            rdat = dat_o;
            acyc = cyc_n;
         end
      end
      cyc = 0; stb = 0; we = 0;
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL wb_ack_timeout actual=no_ack required=ack");
      end else if (w) begin
         case (a)
            4'h0: if (mq.size() >= DEPTH) m_ovf = 1;
                  else mq.push_back(d);
            4'h4: if (d[10]) m_ovf = 0;
            4'h8: cur_gap = int'(d[15:8]);
            default: ;
         endcase
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d,
                     output int acyc);
      logic [31:0] r;
      xfer(1'b1, a, d, r, acyc);
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] r);
      int c;
      xfer(1'b0, a, 32'h0, r, c);
   endtask

   task automatic wait_pulses(input int target, input int budget);
      for (int i = 0; i < budget && pulse_cnt < target; i++)
         @(posedge clk);
      #1;
      checks++;
      if (pulse_cnt < target) begin
         failures++;
         $display("FAIL pulse_timeout actual=%0d required=%0d",
                  pulse_cnt, target);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_valid"}, {31'b0, vld}, 32'h0);
      chk({tag, "_result"}, res, 32'h0);
      chk({tag, "_ack"}, {31'b0, ack}, 32'h0);
      chk({tag, "_dat_o"}, dat_o, 32'h0);
      chk({tag, "_irq"}, {31'b0, irq}, 32'h0);
   endtask

   initial begin
      logic [31:0] r;
      int a1, a2, a3, ac, base;

      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      rst = 0;

      rd(4'h4, r);
      chk("status_reset", r, 32'h0000_0100);
      chk("status_reset_model", r, exp_status());
      rd(4'h8, r);
      chk("ctrl_reset", r, 32'h0);
      rd(4'hC, r);
      chk("txcnt_reset", r, 32'h0);
      rd(4'h0, r);
      chk("data_read_zero", r, 32'h0);

      // Gap 0 stream
      wr(4'h8, 32'h0000_0001, ac);
      wr(4'h0, 32'h0000_00A5, a1);
      wr(4'h0, 32'h0000_003C, a2);
      wr(4'h0, 32'h0000_007F, a3);
      wait_pulses(3, 40);
      if (pcyc.size() >= 3) begin
         chk("latency_first", pcyc[0], a1 + 2);
         chk("spacing_gap0_a", pcyc[1] - pcyc[0], 2);
         chk("spacing_gap0_b", pcyc[2] - pcyc[1], 2);
      end
      rd(4'hC, r);
      chk("txcnt_3", r, 32'd3);
      chk("txcnt_model", r, m_tx);
      rd(4'h8, r);
      chk("ctrl_readback", r, 32'h0000_0001);

      // Gap 3 stream
      wr(4'h8, 32'h0000_0301, ac);
      wr(4'h0, 32'h1111_1111, ac);
      wr(4'h0, 32'h2222_2222, ac);
      wait_pulses(5, 60);
      if (pcyc.size() >= 5)
         chk("spacing_gap3", pcyc[4] - pcyc[3], 5);

      // Overflow with stream disabled
      wr(4'h8, 32'h0, ac);
      for (int i = 0; i < 17; i++)
         wr(4'h0, 32'h100 + i, ac);
      rd(4'h4, r);
      chk("status_full_ovf", r, 32'h0000_0610);
      chk("status_full_model", r, exp_status());
      wr(4'h4, 32'h0000_0400, ac);
      rd(4'h4, r);
      chk("status_ovf_clear", r, 32'h0000_0210);
      chk("status_clear_model", r, exp_status());

      // Drain; the dropped 17th word must never appear
      wr(4'h8, 32'h0000_0001, ac);
      wait_pulses(21, 300);
      repeat (20) @(posedge clk);
      #1;
      chk("pulse_total", pulse_cnt, 21);
      rd(4'h4, r);
      chk("status_drained", r, 32'h0000_0100);
      rd(4'hC, r);
      chk("txcnt_21", r, 32'd21);

      // Reset with words pending
      wr(4'h8, 32'h0, ac);
      for (int i = 0; i < 8; i++)
         wr(4'h0, 32'hBEEF_0000 + i, ac);
      wr(4'h8, 32'h0000_0F01, ac);
      repeat (3) @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk);
      #1;
      chk_outputs_zero("midreset");
      rst = 0;
      mq.delete();
      m_ovf   = 0;
      m_tx    = 0;
      cur_gap = 0;
      base    = pulse_cnt;
      rd(4'h4, r);
      chk("status_after_reset", r, 32'h0000_0100);
      rd(4'h8, r);
      chk("ctrl_after_reset", r, 32'h0);
      rd(4'hC, r);
      chk("txcnt_after_reset", r, 32'h0);
      repeat (40) @(posedge clk);
      #1;
      chk("no_pulse_after_reset", pulse_cnt, base);

      // Interrupt on drain
      wr(4'h8, 32'h0000_0003, ac);
      repeat (2) @(posedge clk);
      #1;
      chk("irq_before", {31'b0, irq}, 32'h0);
      wr(4'h0, 32'hCAFE_0001, ac);
      wr(4'h0, 32'hCAFE_0002, ac);
      wait_pulses(base + 2, 40);
      repeat (4) @(posedge clk);
      #1;
`ifdef WB_STREAMER_IRQ_EN
      chk("irq_drained", {31'b0, irq}, 32'h1);
`else
      chk("irq_drained", {31'b0, irq}, 32'h0);
`endif
      rd(4'hC, r);
      chk("txcnt_final", r, 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_result_streamer.md
Name: wb_result_streamer

Overview:
- Wishbone classic slave that accepts 32-bit result words written by the CPU and buffers them in a FIFO.
- Replays the buffered words as a valid-qualified stream (`alu_result_out` / `alu_valid_out`) to the LED/result capture block, at a programmable pacing.
- This is the producer end of the `alu_result` / `alu_valid` interface; it sits between the SoC Wishbone bus and the board-output capture logic.

Parameters:
- DEPTH, 16, FIFO entries; power of two, range 2..64.
- AW, 4, Wishbone byte-address bits decoded (word registers at 0x0, 0x4, 0x8, 0xC).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  AW  byte address; bits [1:0] are ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid while wb_ack_o = 1.
- wb_ack_o  out  1  single-cycle acknowledge.
- alu_result_out  out  32  streamed word.
- alu_valid_out  out  1  one-cycle qualifier for alu_result_out.
- irq  out  1  interrupt; present only under the optional feature, otherwise tied to 0.

Behaviour:
- Reset: every output is 0; FIFO is empty; CTRL, overflow flag, gap counter and TX_COUNT are 0. Reset in mid-transfer discards FIFO contents and any pending ack.
- Bus handshake:
  - wb_ack_o is registered: it is 1 in the cycle after cyc & stb & !ack, then returns to 0. Fixed one-wait-state latency.
  - Side effects (push, clear, CTRL update) commit on the same edge that raises ack.
- Register map:
  - 0x0 DATA: a write pushes wb_dat_i; a read returns 0.
  - 0x4 STATUS (read): [7:0] count, [8] empty, [9] full, [10] overflow (sticky). Writing 1 to bit 10 clears overflow; other bits are read-only.
  - 0x8 CTRL (R/W): [0] enable, [1] irq_en, [15:8] gap.
  - 0xC TX_COUNT (read-only): number of words emitted, 32-bit, wraps 0xFFFFFFFF -> 0.
- FIFO:
  - The full check uses the count before the edge. A DATA write while full drops the word, sets overflow and still acks; this holds even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
- Stream engine, two states:
  - IDLE -> EMIT when enable = 1, count > 0 (pre-edge) and gap counter = 0.
  - EMIT: pop the head, drive it on alu_result_out with alu_valid_out = 1 for exactly one cycle, increment TX_COUNT, load gap counter with CTRL.gap.
  - EMIT -> IDLE unconditionally.
  - In IDLE the gap counter decrements to 0 and saturates.
  - Minimum spacing between valids is 2 + gap cycles.
- Latency: a word written to an empty, enabled FIFO with gap counter 0 appears on alu_valid_out 2 cycles after the ack cycle. The ack edge commits the push, the next edge enters EMIT.
- alu_result_out holds its last value when alu_valid_out = 0.
- Clearing enable mid-stream: a pulse already in EMIT completes; no further pops. The gap counter keeps decrementing.
- Reads of unmapped bits return 0.

Optional Feature:
- Macro: WB_STREAMER_IRQ_EN.
- Defined: irq = overflow | (CTRL.irq_en & empty & TX_COUNT != 0). The output is registered and follows its inputs one cycle later.
- Undefined: irq is constant 0; CTRL bit 1 reads back as written but has no effect.

Decomposition:
- Package wb_streamer_pkg holds:
  - register offset constants (REG_DATA, REG_STATUS, REG_CTRL, REG_TXCNT);
  - STATUS and CTRL bit-position constants;
  - the stream state enum (ST_IDLE, ST_EMIT).
- One sub-module, sync_fifo: parameterised depth and width, push/pop/full/empty/count, first-word-fall-through head.

Test Plan:
- Reset, then read STATUS -> 0x00000100 (empty); read CTRL -> 0; alu_valid_out = 0 throughout.
- CTRL = 0x00000001 (gap 0); write DATA 0xA5, 0x3C, 0x7F back-to-back -> three valid pulses carrying 0xA5, 0x3C, 0x7F in order, spaced 2 cycles apart; TX_COUNT = 3.
- CTRL = 0x00000301 (gap 3); push 2 words -> valid pulses 5 cycles apart.
- enable = 0; push 17 words with DEPTH = 16 -> STATUS reads count 16, full, overflow; the 17th word is never emitted. Write 0x400 to STATUS -> overflow clears.
- Enable, then assert rst while 8 words are pending -> next cycle all outputs are 0 and count is 0; no further pulses.
- With WB_STREAMER_IRQ_EN and irq_en = 1: after the last of 2 words drains -> irq = 1. Without the macro -> irq stays 0.
